// File: rtl/wb_ram_pkg.sv
// Shared constants, FSM state type and geometry helpers for the banked Wishbone SRAM wrapper.

package wb_ram_pkg;

  localparam int unsigned BANK_WORDS = 512;
  localparam int unsigned BANK_ADR_W = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  function automatic int unsigned calc_nr_banks(input int unsigned depth);
    return depth / BANK_WORDS;
  endfunction

  function automatic int unsigned calc_adr_w(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    return (w > BANK_ADR_W) ? w : BANK_ADR_W;
  endfunction

  function automatic int unsigned calc_bank_bits(input int unsigned nr_banks);
    return $clog2(nr_banks);
  endfunction

  // A single bank still needs a 1-bit index signal to keep port widths legal.
  function automatic int unsigned calc_bank_idx_w(input int unsigned nr_banks);
    return (nr_banks > 1) ? calc_bank_bits(nr_banks) : 1;
  endfunction

endpackage

// File: rtl/ram512x32.sv
// Behavioural stand-in for the 512x32 SRAM macro: synchronous read, per-byte write enables.

module ram512x32 (
`ifdef USE_POWER_PINS
  inout  wire         vccd1,
  inout  wire         vssd1,
`endif
  input  logic        clk_i,
  input  logic        en_i,
  input  logic [3:0]  we_i,
  input  logic [8:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o
);

  logic [31:0] mem [512];

  // Read-before-write: dat_o always returns the old word at the addressed location.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int l = 0; l < 4; l++) begin
        if (we_i[l]) mem[adr_i][8*l +: 8] <= dat_i[8*l +: 8];
      end
      dat_o <= mem[adr_i];
    end
  end

endmodule

// File: rtl/wb_ram_bank_array.sv
// Array of ram512x32 macros with one-hot enable decode and a registered-bank read mux.

module wb_ram_bank_array
  import wb_ram_pkg::*;
#(
  parameter  int unsigned NR_BANKS = 4,
  localparam int unsigned BankIdxW = calc_bank_idx_w(NR_BANKS)
) (
`ifdef USE_POWER_PINS
  inout  wire                vccd1,
  inout  wire                vssd1,
`endif
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [3:0]            sel_i,
  input  logic [BankIdxW-1:0]   bank_i,
  input  logic [BANK_ADR_W-1:0] index_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [BankIdxW-1:0] bank_q;
  logic [31:0]         bank_dout [NR_BANKS];
  logic [3:0]          lane_we;

  assign lane_we = we_i ? sel_i : 4'b0000;

  // The bank index follows each accepted request so the read mux stays on that macro.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_q <= '0;
    end else if (req_i) begin
      bank_q <= bank_i;
    end
  end

  for (genvar b = 0; b < NR_BANKS; b++) begin : g_bank
    logic bank_en;
    assign bank_en = req_i && (bank_i == BankIdxW'(b));

    ram512x32 u_ram (
`ifdef USE_POWER_PINS
      .vccd1 (vccd1),
      .vssd1 (vssd1),
`endif
      .clk_i (clk_i),
      .en_i  (bank_en),
      .we_i  (lane_we),
      .adr_i (index_i),
      .dat_i (wdata_i),
      .dat_o (bank_dout[b])
    );
  end

  always_comb begin
    rdata_o = '0;
    for (int b = 0; b < NR_BANKS; b++) begin
      if (bank_q == BankIdxW'(b)) rdata_o = bank_dout[b];
    end
  end

endmodule

// File: rtl/wb_ram_banked.sv
// Wishbone classic slave over banked SRAM: one ack/err per transfer, optional read register,
// bus error on addresses at or beyond DEPTH.

module wb_ram_banked
  import wb_ram_pkg::*;
#(
  parameter  int unsigned DEPTH   = 2048,
  parameter  int unsigned OUT_REG = 0,
  parameter  int unsigned ERR_EN  = 1,
  localparam int unsigned ADR_W   = calc_adr_w(DEPTH)
) (
`ifdef USE_POWER_PINS
  inout  wire              vccd1,
  inout  wire              vssd1,
`endif
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [ADR_W-1:0] wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o
);

  localparam int unsigned NrBanks  = calc_nr_banks(DEPTH);
  localparam int unsigned BankBits = calc_bank_bits(NrBanks);
  localparam int unsigned BankIdxW = calc_bank_idx_w(NrBanks);
  localparam logic        ErrEn    = (ERR_EN != 0);
  localparam logic        OutReg   = (OUT_REG != 0);

  if ((DEPTH % BANK_WORDS) != 0 || DEPTH < BANK_WORDS) begin : g_bad_depth
    $error("wb_ram_banked: DEPTH must be a non-zero multiple of 512");
  end

  state_t state_q, state_d;
  logic   we_q, we_d;
  logic   err_q, err_d;

  logic                req;
  logic                in_range;
  logic                mem_req;
  logic [BankIdxW-1:0] bank;
  logic [31:0]         bank_rdata;
  logic [31:0]         rdata;
  logic                resp;

  assign req      = wb_cyc_i & wb_stb_i;
  assign in_range = 32'(wb_adr_i) < DEPTH;
  // Macro is only touched in IDLE, so a write commits exactly once at the request edge.
  assign mem_req  = (state_q == IDLE) & req & in_range;

  if (NrBanks > 1) begin : g_multi_bank
    assign bank = wb_adr_i[BANK_ADR_W +: BankBits];
  end else begin : g_single_bank
    assign bank = '0;
  end

  wb_ram_bank_array #(
    .NR_BANKS (NrBanks)
  ) u_bank_array (
`ifdef USE_POWER_PINS
    .vccd1   (vccd1),
    .vssd1   (vssd1),
`endif
    .clk_i   (clk_i),
    .rst_ni  (rst_in),
    .req_i   (mem_req),
    .we_i    (wb_we_i),
    .sel_i   (wb_sel_i),
    .bank_i  (bank),
    .index_i (wb_adr_i[BANK_ADR_W-1:0]),
    .wdata_i (wb_dat_i),
    .rdata_o (bank_rdata)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = wb_we_i;
          err_d   = ~in_range;
          state_d = (OutReg && !wb_we_i && in_range) ? RD_WAIT : RESP;
        end
      end
      RD_WAIT: state_d = wb_cyc_i ? RESP : IDLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  if (OutReg) begin : g_out_reg
    logic [31:0] rd_q;
    always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
        rd_q <= '0;
      end else if (state_q == RD_WAIT) begin
        rd_q <= bank_rdata;
      end
    end
    assign rdata = rd_q;
  end else begin : g_no_out_reg
    assign rdata = bank_rdata;
  end

  // Responses are qualified by cyc so an abort in RESP never shows a strobe.
  assign resp     = (state_q == RESP) & wb_cyc_i;
  assign wb_err_o = resp & err_q & ErrEn;
  assign wb_ack_o = resp & ~(err_q & ErrEn);
  assign wb_dat_o = (wb_ack_o & ~we_q & ~err_q) ? rdata : 32'h0;

endmodule

// File: tb/tb_wb_ram_banked.sv
// Directed bench for wb_ram_banked across four configurations (plain, OUT_REG, DEPTH=1536 +/- ERR_EN).

module tb_wb_ram_banked;

  localparam int NDUT = 4;
  localparam int AW   = 11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          cyc  [NDUT];
  logic          stb  [NDUT];
  logic          we   [NDUT];
  logic [3:0]    sel  [NDUT];
  logic [AW-1:0] adr  [NDUT];
  logic [31:0]   wdat [NDUT];
  logic [31:0]   rdat [NDUT];
  logic          ack  [NDUT];
  logic          err  [NDUT];

  wb_ram_banked #(.DEPTH(2048), .OUT_REG(0), .ERR_EN(1)) u_d0 (
    .clk_i(clk), .rst_in(rst_n), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
    .wb_sel_i(sel[0]), .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]),
    .wb_ack_o(ack[0]), .wb_err_o(err[0])
  );
  wb_ram_banked #(.DEPTH(2048), .OUT_REG(1), .ERR_EN(1)) u_d1 (
    .clk_i(clk), .rst_in(rst_n), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
    .wb_sel_i(sel[1]), .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]),
    .wb_ack_o(ack[1]), .wb_err_o(err[1])
  );
  wb_ram_banked #(.DEPTH(1536), .OUT_REG(0), .ERR_EN(1)) u_d2 (
    .clk_i(clk), .rst_in(rst_n), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_we_i(we[2]),
    .wb_sel_i(sel[2]), .wb_adr_i(adr[2]), .wb_dat_i(wdat[2]), .wb_dat_o(rdat[2]),
    .wb_ack_o(ack[2]), .wb_err_o(err[2])
  );
  wb_ram_banked #(.DEPTH(1536), .OUT_REG(0), .ERR_EN(0)) u_d3 (
    .clk_i(clk), .rst_in(rst_n), .wb_cyc_i(cyc[3]), .wb_stb_i(stb[3]), .wb_we_i(we[3]),
    .wb_sel_i(sel[3]), .wb_adr_i(adr[3]), .wb_dat_i(wdat[3]), .wb_dat_o(rdat[3]),
    .wb_ack_o(ack[3]), .wb_err_o(err[3])
  );

  typedef struct {
    int            d;
    logic          w;
    logic [3:0]    s;
    logic [AW-1:0] a;
    logic [31:0]   wd;
    int            lat;
    logic          e;
    logic [31:0]   dat;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input int d, input logic w, input logic [3:0] s,
                              input logic [AW-1:0] a, input logic [31:0] wd, input int lat,
                              input logic e, input logic [31:0] dat);
    vec_t v;
    v.d = d; v.w = w; v.s = s; v.a = a; v.wd = wd; v.lat = lat; v.e = e; v.dat = dat;
    return v;
  endfunction

  task automatic idle_bus(input int d);
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; sel[d] = 4'h0; adr[d] = '0; wdat[d] = '0;
  endtask

  // Starts and ends on a falling edge; C0 is the cycle the request is first presented.
  task automatic xfer(input int d, input logic w, input logic [3:0] s, input logic [AW-1:0] a,
                      input logic [31:0] wd, output int lat, output logic got_err,
                      output logic [31:0] got_dat, output int n_resp, output logic gate_bad);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; wdat[d] = wd;
    lat = 0; got_err = 1'b0; got_dat = '0; n_resp = 0; gate_bad = 1'b0;
    #1;
    if (ack[d] || err[d] || rdat[d] != 32'h0) gate_bad = 1'b1;
    for (int k = 1; k <= 5 && lat == 0; k++) begin
      @(negedge clk);
      if (!ack[d] && rdat[d] != 32'h0) gate_bad = 1'b1;
      if (ack[d] && err[d]) gate_bad = 1'b1;
      if (ack[d] || err[d]) begin
        lat = k; got_err = err[d]; got_dat = rdat[d]; n_resp++;
      end
    end
    idle_bus(d);
    @(negedge clk);
    if (ack[d] || err[d]) n_resp++;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int          lat, n_resp;
    logic        got_err, gate_bad;
    logic [31:0] got_dat;
    xfer(v.d, v.w, v.s, v.a, v.wd, lat, got_err, got_dat, n_resp, gate_bad);
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " err"}, {31'h0, got_err}, {31'h0, v.e});
    check({tag, " data"}, got_dat, v.dat);
    check({tag, " single resp/gating"}, {30'h0, n_resp == 1, !gate_bad}, 32'h3);
  endtask

  initial begin
    int   resp_cnt;
    logic [15:0] ack_mask;
    logic dat_bad;

    for (int d = 0; d < NDUT; d++) idle_bus(d);
    rst_n = 1'b0;

    // Cross-bank, byte lanes, bank boundaries (DEPTH=2048, OUT_REG=0)
    vecs.push_back(mk(0, 1, 4'hF, 11'h205, 32'hDEADBEEF, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 4'hF, 11'h005, 32'hCAFEF00D, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 4'hF, 11'h205, 32'h0,        1, 0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 4'hF, 11'h005, 32'h0,        1, 0, 32'hCAFEF00D));
    vecs.push_back(mk(0, 1, 4'hF, 11'h010, 32'h11223344, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 4'h2, 11'h010, 32'h0000AB00, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 4'hF, 11'h010, 32'h0,        1, 0, 32'h1122AB44));
    vecs.push_back(mk(0, 1, 4'h0, 11'h010, 32'hFFFFFFFF, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 4'hF, 11'h010, 32'h0,        1, 0, 32'h1122AB44));
    vecs.push_back(mk(0, 1, 4'hF, 11'h1FF, 32'h01FF01FF, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 4'hF, 11'h7FF, 32'hA5A55A5A, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 4'h0, 11'h1FF, 32'h0,        1, 0, 32'h01FF01FF));
    vecs.push_back(mk(0, 0, 4'hF, 11'h7FF, 32'h0,        1, 0, 32'hA5A55A5A));
    vecs.push_back(mk(0, 0, 4'hF, 11'h205, 32'h0,        1, 0, 32'hDEADBEEF));
    // OUT_REG=1: reads ack in C2
    vecs.push_back(mk(1, 1, 4'hF, 11'h3FF, 32'h0BADF00D, 1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 4'hF, 11'h3FF, 32'h0,        2, 0, 32'h0BADF00D));
    vecs.push_back(mk(1, 1, 4'hF, 11'h400, 32'h13572468, 1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 4'hF, 11'h400, 32'h0,        2, 0, 32'h13572468));
    // DEPTH=1536, ERR_EN=1
    vecs.push_back(mk(2, 1, 4'hF, 11'h000, 32'h55AA55AA, 1, 0, 32'h0));
    vecs.push_back(mk(2, 1, 4'hF, 11'h600, 32'h12345678, 1, 1, 32'h0));
    vecs.push_back(mk(2, 0, 4'hF, 11'h000, 32'h0,        1, 0, 32'h55AA55AA));
    vecs.push_back(mk(2, 0, 4'hF, 11'h7FF, 32'h0,        1, 1, 32'h0));
    vecs.push_back(mk(2, 1, 4'hF, 11'h5FF, 32'h0F0F0F0F, 1, 0, 32'h0));
    vecs.push_back(mk(2, 0, 4'hF, 11'h5FF, 32'h0,        1, 0, 32'h0F0F0F0F));
    // DEPTH=1536, ERR_EN=0: out-of-range acks as a no-op returning 0
    vecs.push_back(mk(3, 1, 4'hF, 11'h000, 32'h77777777, 1, 0, 32'h0));
    vecs.push_back(mk(3, 1, 4'hF, 11'h600, 32'h12345678, 1, 0, 32'h0));
    vecs.push_back(mk(3, 0, 4'hF, 11'h600, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(3, 0, 4'hF, 11'h000, 32'h0,        1, 0, 32'h77777777));

    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++)
      check($sformatf("reset outputs d%0d", d), {ack[d], err[d], rdat[d][29:0]}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec($sformatf("v%0d", i), vecs[i]);

    // OUT_REG=1 read with stb held: acks in C2, C5, C8
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF; adr[1] = 11'h3FF;
    ack_mask = '0; dat_bad = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      ack_mask[k] = ack[1];
      if (ack[1] && rdat[1] != 32'h0BADF00D) dat_bad = 1'b1;
      if (!ack[1] && rdat[1] != 32'h0) dat_bad = 1'b1;
    end
    idle_bus(1);
    @(negedge clk);
    check("held stb ack pattern", {16'h0, ack_mask}, 32'h0000_0124);
    check("held stb data", {31'h0, dat_bad}, 32'h0);

    // Abort: cyc dropped in RD_WAIT gives no response
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF; adr[1] = 11'h400;
    @(negedge clk);
    idle_bus(1);
    resp_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ack[1] || err[1]) resp_cnt++;
    end
    check("abort no response", 32'(resp_cnt), 32'h0);
    run_vec("post-abort read", mk(1, 0, 4'hF, 11'h3FF, 32'h0, 2, 0, 32'h0BADF00D));

    // Reset asserted during RESP: ack drops at once, memory survives
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; sel[0] = 4'hF; adr[0] = 11'h205;
    @(negedge clk);
    check("pre-reset ack", {31'h0, ack[0]}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("reset drops ack/dat", {ack[0], err[0], rdat[0][29:0]}, 32'h0);
    idle_bus(0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec("post-reset 0x205", mk(0, 0, 4'hF, 11'h205, 32'h0, 1, 0, 32'hDEADBEEF));
    run_vec("post-reset 0x010", mk(0, 0, 4'hF, 11'h010, 32'h0, 1, 0, 32'h1122AB44));
    run_vec("post-reset d2",    mk(2, 0, 4'hF, 11'h000, 32'h0, 1, 0, 32'h55AA55AA));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_ram_banked.md
Name: wb_ram_banked

Overview:
Parametrised Wishbone classic slave that wraps an array of ram512x32 macros.
It replaces the single-rule "ack = cyc & stb" wrapper with a request FSM that gives:
- exactly one ack per transfer,
- an optional registered read path,
- a bus error for addresses beyond DEPTH.

It sits between the core/peripheral interconnect and on-chip SRAM, one instance per memory region.

Parameters:
- DEPTH, 2048: total words. Must be a multiple of 512 and at least 512; it does not need to be a power of two.
- OUT_REG, 0: 1 adds a read-data register, so read ack latency goes from 1 to 2 cycles.
- ERR_EN, 1: 1 makes out-of-range accesses assert wb_err_o. 0 acks them as no-ops returning 0.
- Derived, not overridable: NR_BANKS = DEPTH/512; BANK_BITS = $clog2(NR_BANKS); ADR_W = max(9, $clog2(DEPTH)).

Ports:
- clk_i  in  1  single clock, all logic rising-edge.
- rst_in  in  1  reset, asynchronous assert, active-low.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte lane enables.
- wb_adr_i  in  ADR_W  word address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, nonzero only while wb_ack_o=1.
- wb_ack_o  out  1  single-cycle acknowledge.
- wb_err_o  out  1  single-cycle error, out-of-range access.

Behaviour:
- Reset (rst_in=0, asynchronous): state=IDLE; wb_ack_o=0, wb_err_o=0, wb_dat_o=0; bank and read registers cleared. Macro contents are not touched.
- FSM states (enum in package): IDLE, RD_WAIT, RESP.
- IDLE:
  - A request is cyc&stb sampled high at the edge. Its cycle is C0.
  - In range (adr < DEPTH):
    - Present macro wen/sel/adr/dat in C0; bank = adr[9+BANK_BITS-1:9], index = adr[8:0].
    - Latch bank index and we.
    - Next state: RESP, or RD_WAIT if OUT_REG=1 and the access is a read.
  - Out of range: no macro enable; next state RESP with err flag set.
- RD_WAIT (OUT_REG=1 reads only): in C1, capture the latched bank's dat_o into the read register. Next state RESP.
- RESP: exactly one cycle.
  - Assert wb_ack_o, or wb_err_o if err flag set and ERR_EN=1. Ack and err are never both high.
  - Next state is always IDLE. A request still held high in RESP is not re-sampled; it is decoded in the following IDLE cycle.
  - Maximum throughput is therefore one transfer per 2 cycles (3 for OUT_REG=1 reads).
- Latency, request cycle C0 to ack cycle:
  - Write: ack in C1.
  - Read, OUT_REG=0: ack in C1; wb_dat_o = mux of latched bank's macro output.
  - Read, OUT_REG=1: ack in C2; wb_dat_o = read register.
  - Error: err in C1.
- wb_dat_o is gated to 32'h0 whenever wb_ack_o=0, and also for writes and errors.
- Byte lanes: on a write, only lanes with sel=1 change. sel=0000 with we=1 still acks with memory unchanged. Reads ignore sel.
- Write commit: the macro write occurs at the C0 edge only. Writes are never repeated and never occur in RD_WAIT or RESP.
- Abort: cyc_i=0 while in RD_WAIT or RESP sends the FSM to IDLE next edge with ack/err suppressed. A write already committed at C0 stays committed.
- Reset mid-operation: outputs drop immediately (asynchronously). The FSM restarts in IDLE after rst_in rises. Any partially completed read is discarded.
- Out-of-range example, DEPTH=1536: ADR_W=11, addresses 0x600..0x7FF give err.

Decomposition:
- wb_ram_pkg holds:
  - BANK_WORDS=512 and BANK_ADR_W=9;
  - state_t enum {IDLE, RD_WAIT, RESP};
  - functions computing NR_BANKS and ADR_W from DEPTH.
- One sub-module, wb_ram_bank_array. It instantiates NR_BANKS ram512x32 macros (USE_POWER_PINS passthrough) with a one-hot wen decode and a registered-bank-index read mux.
- wb_ram_banked holds the FSM, range check, output gating and the OUT_REG register.

Test Plan:
- Cross-bank write then read, DEPTH=2048, OUT_REG=0:
  - write 0xDEADBEEF to 0x205 and 0xCAFEF00D to 0x005;
  - read 0x205 -> ack in C1, dat 0xDEADBEEF; read 0x005 -> 0xCAFEF00D.
- Byte-lane write to 0x010:
  - write 0x11223344 with sel=1111, then write 0x0000AB00 with sel=0010;
  - read -> 0x1122AB44.
- OUT_REG=1 read timing:
  - read 0x3FF after writing 0x0BADF00D;
  - ack exactly in C2, wb_dat_o=0 in C0/C1, 0x0BADF00D in C2; stb held high yields one ack per 3 cycles.
- Out of range, DEPTH=1536, ERR_EN=1:
  - write 0x12345678 to 0x600 -> wb_err_o=1 in C1, ack never high;
  - read 0x000 is unchanged from before. With ERR_EN=0: ack in C1, dat 0.
- Abort and reset:
  - read with cyc dropped in RD_WAIT -> no ack/err, next request acks normally;
  - rst_in=0 asserted during RESP -> ack falls the same cycle;
  - data written before the reset reads back intact.
